// File: rtl/trip_latch_debounce.sv
// Per-channel trip debounce and latch feeding the voting logic; outputs registered one edge after a sample.
// Trips latch until an operator reset is accepted with the last raw sample clear; invalid mode fails safe as tripped.
module trip_latch_debounce #(
  parameter int NChannels     = 3,
  parameter int DebounceCount = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [NChannels-1:0]   sensor_trips,
  input  logic [2*NChannels-1:0] mode,
  input  logic [NChannels-1:0]   trip_reset,
  output logic [NChannels-1:0]   trip_out,
  output logic                   trip_valid,
  output logic [NChannels-1:0]   mode_err
);

  localparam int CntW = 4;
  localparam logic [CntW-1:0] DebCnt = CntW'(DebounceCount);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  // Channels are handled by bit position; channel 0 sits at the MSB of every vector.
  state_t              r_state     [NChannels];
  state_t              w_state_nxt [NChannels];
  logic [CntW-1:0]     r_cnt       [NChannels];
  logic [CntW-1:0]     w_cnt_nxt   [NChannels];
  logic [CntW-1:0]     w_cnt_inc   [NChannels];
  logic [NChannels-1:0] r_raw_q;
  logic [NChannels-1:0] r_mode_err;
  logic [NChannels-1:0] w_raw;
  logic [NChannels-1:0] w_mode3;
  logic                 r_trip_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NChannels; b++) begin
        r_state[b] <= IDLE;
        r_cnt[b]   <= '0;
      end
      r_raw_q      <= '0;
      r_mode_err   <= '0;
      r_trip_valid <= 1'b0;
    end else begin
      for (int b = 0; b < NChannels; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_cnt[b]   <= w_cnt_nxt[b];
      end
      if (sample_valid) begin
        r_raw_q    <= w_raw;
        r_mode_err <= r_mode_err | w_mode3;
      end
      r_trip_valid <= sample_valid;
    end
  end

  always_comb begin
    w_raw   = '0;
    w_mode3 = '0;
    for (int b = 0; b < NChannels; b++) begin
      w_state_nxt[b] = r_state[b];
      w_cnt_nxt[b]   = r_cnt[b];
      w_cnt_inc[b]   = r_cnt[b] + CntW'(1);
      w_mode3[b]     = (mode[2*b +: 2] == 2'd3);
      w_raw[b]       = (mode[2*b +: 2] == 2'd2) || (mode[2*b +: 2] == 2'd3) ||
                       ((mode[2*b +: 2] == 2'd1) && sensor_trips[b]);
      if (sample_valid) begin
        case (mode[2*b +: 2])
          2'd0: begin
            w_state_nxt[b] = IDLE;
            w_cnt_nxt[b]   = '0;
          end
          2'd1: begin
            if (sensor_trips[b]) begin
              if (r_state[b] != TRIPPED) begin
                if (w_cnt_inc[b] >= DebCnt) begin
                  w_state_nxt[b] = TRIPPED;
                  w_cnt_nxt[b]   = DebCnt;
                end else begin
                  w_state_nxt[b] = PENDING;
                  w_cnt_nxt[b]   = w_cnt_inc[b];
                end
              end
            end else if ((r_state[b] != TRIPPED) || trip_reset[b]) begin
              // A clear sample together with reset releases a latched trip on this edge.
              w_state_nxt[b] = IDLE;
              w_cnt_nxt[b]   = '0;
            end
          end
          default: begin
            w_state_nxt[b] = TRIPPED;
            w_cnt_nxt[b]   = DebCnt;
          end
        endcase
      end else if ((r_state[b] == TRIPPED) && trip_reset[b] && !r_raw_q[b]) begin
        w_state_nxt[b] = IDLE;
        w_cnt_nxt[b]   = '0;
      end
    end
  end

  always_comb begin
    trip_out = '0;
    for (int b = 0; b < NChannels; b++) begin
      trip_out[b] = (r_state[b] == TRIPPED);
    end
  end

  assign trip_valid = r_trip_valid;
  assign mode_err   = r_mode_err;

endmodule

// File: doc/trip_latch_debounce.md
Name: trip_latch_debounce

Overview:
- Sequential stage directly downstream of the per-channel sensor-trip generation in the RTS instrumentation path.
- Accepts per-channel sensor trip bits and per-channel mode (bypass / operate / manual trip), and debounces sensor trips over consecutive samples.
- Latches each channel trip until an operator reset is accepted.
- Presents registered, fail-safe trip bits to the downstream voting logic, with a one-cycle valid strobe per sample.

Parameters:
- NChannels, 3, number of instrumentation channels.
- DebounceCount, 3, consecutive tripped samples in operate mode required to latch; legal range 1..15.
- CntW, 4, counter width; localparam, must hold DebounceCount.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe; sensor_trips and mode are sampled on this cycle.
- sensor_trips  input  NChannels  raw comparator trips; channel 0 at MSB.
- mode  input  2*NChannels  per-channel mode, 2 bits each, channel 0 in the top 2 bits. Encoding: 0 bypass, 1 operate, 2 manual trip, 3 invalid.
- trip_reset  input  NChannels  per-channel operator reset request, level, channel 0 at MSB.
- trip_out  output  NChannels  latched channel trip to voting, channel 0 at MSB.
- trip_valid  output  1  one-cycle pulse: trip_out updated from a sample.
- mode_err  output  NChannels  sticky flag: invalid mode (3) seen on that channel.

Behaviour:
- Reset (rst_n low, asynchronous): trip_out=0, trip_valid=0, mode_err=0, all counters=0, all raw_q=0, all channels in IDLE. Deasserting reset mid-debounce restarts counting from 0.
- raw condition per channel, evaluated on each sample_valid cycle:
  - raw = (mode==2) | (mode==3) | (mode==1 & sensor_trip).
  - Mode 3 is treated as tripped (fail-safe) and sets mode_err for that channel; mode_err clears only on reset.
- raw_q: registers the raw value on every sample_valid; holds otherwise.
- Per-channel FSM states:
  - IDLE: counter 0, trip_out 0.
  - PENDING: 0 < counter < DebounceCount, trip_out 0.
  - TRIPPED: trip_out 1.
- Transitions, on sample_valid only:
  - mode 2 or 3, from any state -> TRIPPED immediately; no debounce.
  - mode 1 with sensor_trip=1: counter increments, saturating at DebounceCount. Enter TRIPPED on the sample where counter+1 reaches DebounceCount. DebounceCount=1 -> TRIPPED on the first tripped sample.
  - mode 1 with sensor_trip=0 in IDLE/PENDING: counter=0, state IDLE. Counting requires consecutive samples; any non-tripped sample restarts it.
  - mode 1 with sensor_trip=0 in TRIPPED: remains TRIPPED (latched).
  - mode 0 (bypass), from any state: counter=0, state IDLE, trip_out=0. Bypass drops a latched trip.
  - Cycles without sample_valid: counters and state hold, except the trip_reset path.
- trip_reset, evaluated every cycle independent of sample_valid:
  - TRIPPED channel with trip_reset=1 and raw_q=0 -> IDLE, counter=0, trip_out=0 on the next edge.
  - trip_reset with raw_q=1 is ignored; the channel stays TRIPPED.
  - trip_reset in IDLE/PENDING has no effect; it does not clear a PENDING count.
- Simultaneous sample_valid and trip_reset on a channel:
  - The new raw value takes priority.
  - If new raw=1, the trip sets or remains set.
  - If new raw=0 and the channel was TRIPPED, reset is accepted on that edge, and the mode 1 no-trip rule applies (IDLE).
- Latency: trip_out and trip_valid update on the clock edge after the sample_valid cycle; trip_valid is high for exactly one cycle per sample. Back-to-back sample_valid yields back-to-back trip_valid.
- Reset-driven trip_out changes (no sample) do not pulse trip_valid.
- Channels are fully independent; no cross-channel interaction.

Test Plan:
- Reset, then 3 samples with sensor_trips=3'b100, mode=all 1 (DebounceCount=3) -> trip_out=3'b000 after samples 1 and 2, 3'b100 after sample 3. trip_valid pulses 3 times, one cycle after each strobe.
- Channel 1 in operate, tripped samples T,T,N,T,T,T -> ch1 trip_out rises only after the 6th sample; counter restarts at the N sample.
- Latched ch0, then trip_reset=3'b100 while last sample raw=1 -> trip_out stays 3'b100. Next sample with sensor=0 -> stays latched. Then trip_reset -> trip_out=3'b000 one cycle later, with no trip_valid pulse.
- mode ch2=2 with sensor_trips=0 -> ch2 trip_out=1 after one sample. mode ch2=3 -> trip_out=1 and mode_err=3'b001. Then mode ch2=0 -> trip_out=0 while mode_err stays 3'b001.
- Same cycle: sample_valid with sensor=0, mode=1, trip_reset=1 on a latched channel -> channel clears. Same cycle with sensor=1 instead -> channel stays tripped.
- Assert rst_n low asynchronously mid-cycle during PENDING (count 2) -> all outputs 0 immediately. After release, 2 tripped samples -> no trip; a 3rd -> trip.
